mouse_master_sm: RTL and testbench

- Top-level sequencer for the PS/2 mouse link. It drives the transmitter (SEND_BYTE / BYTE_TO_SEND / BYTE_SENT) and the receiver (READ_ENABLE / BYTE_READY).
- Runs the power-up handshake: reset 0xFF, ACK 0xFA, self-test 0xAA, ID 0x00, then enable-streaming 0xF4 and ACK 0xFA.
- Then collects 3-byte movement packets and publishes status, DX and DY with a one-cycle SEND_INTERRUPT strobe to the downstream position logic.

---
 rtl/mouse_master_sm.sv | 141 ++++++++++++++
 tb/tb_mouse_master_sm.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_master_sm.sv
// PS/2 mouse master sequencer: power-up handshake, then 3-byte packet collection and publish.
// Optional build macro MOUSE_STREAM_WATCHDOG_EN adds a mid-packet receive watchdog.
module mouse_master_sm #(
  parameter int unsigned INIT_WAIT    = 5_000_000,
  parameter int unsigned RESP_TIMEOUT = 50_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic [3:0] MASTER_STATE
);

  typedef enum logic [3:0] {
    INIT         = 4'd0,
    SEND_FF      = 4'd1,
    WAIT_SENT_FF = 4'd2,
    WAIT_FA1     = 4'd3,
    WAIT_AA      = 4'd4,
    WAIT_ID      = 4'd5,
    SEND_F4      = 4'd6,
    WAIT_SENT_F4 = 4'd7,
    WAIT_FA2     = 4'd8,
    STREAM_B1    = 4'd9,
    STREAM_B2    = 4'd10,
    STREAM_B3    = 4'd11,
    PUBLISH      = 4'd12
  } state_t;

`ifdef MOUSE_STREAM_WATCHDOG_EN
  localparam bit WATCHDOG = 1'b1;
`else
  localparam bit WATCHDOG = 1'b0;
`endif

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg;
  logic [7:0]  shadow_status_reg, shadow_dx_reg, shadow_dy_reg;
  logic        rx_good, init_done, timeout, is_wait, in_mid_packet;

  function automatic logic is_read_state(state_t s);
    return (s == WAIT_FA1) || (s == WAIT_AA) || (s == WAIT_ID) || (s == WAIT_FA2) ||
           (s == STREAM_B1) || (s == STREAM_B2) || (s == STREAM_B3);
  endfunction

  assign rx_good       = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
  assign init_done     = (cnt_reg == INIT_WAIT - 1);
  assign timeout       = (cnt_reg == RESP_TIMEOUT - 1);
  assign is_wait       = (state_reg == WAIT_SENT_FF) || (state_reg == WAIT_SENT_F4) ||
                         (state_reg == WAIT_FA1) || (state_reg == WAIT_AA) ||
                         (state_reg == WAIT_ID) || (state_reg == WAIT_FA2);
  assign in_mid_packet = (state_reg == STREAM_B2) || (state_reg == STREAM_B3);
  assign MASTER_STATE  = state_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT:         if (init_done) state_next = SEND_FF;
      SEND_FF:      state_next = WAIT_SENT_FF;
      WAIT_SENT_FF: if (BYTE_SENT) state_next = WAIT_FA1; else if (timeout) state_next = INIT;
      WAIT_FA1:
        if (BYTE_READY) state_next = (rx_good && BYTE_READ == 8'hFA) ? WAIT_AA : INIT;
        else if (timeout) state_next = INIT;
      WAIT_AA:
        if (BYTE_READY) state_next = (rx_good && BYTE_READ == 8'hAA) ? WAIT_ID : INIT;
        else if (timeout) state_next = INIT;
      WAIT_ID:
        if (BYTE_READY) state_next = (rx_good && BYTE_READ == 8'h00) ? SEND_F4 : INIT;
        else if (timeout) state_next = INIT;
      SEND_F4:      state_next = WAIT_SENT_F4;
      WAIT_SENT_F4: if (BYTE_SENT) state_next = WAIT_FA2; else if (timeout) state_next = INIT;
      WAIT_FA2:
        if (BYTE_READY) state_next = (rx_good && BYTE_READ == 8'hFA) ? STREAM_B1 : INIT;
        else if (timeout) state_next = INIT;
      // A byte arriving during PUBLISH is treated as a first packet byte
      STREAM_B1, PUBLISH:
        state_next = (rx_good && BYTE_READ[3]) ? STREAM_B2 : STREAM_B1;
      STREAM_B2:
        if (BYTE_READY) state_next = rx_good ? STREAM_B3 : STREAM_B1;
        else if (WATCHDOG && timeout) state_next = STREAM_B1;
      STREAM_B3:
        if (BYTE_READY) state_next = rx_good ? PUBLISH : STREAM_B1;
        else if (WATCHDOG && timeout) state_next = STREAM_B1;
      default:      state_next = INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg         <= INIT;
      cnt_reg           <= '0;
      shadow_status_reg <= '0;
      shadow_dx_reg     <= '0;
      shadow_dy_reg     <= '0;
      SEND_BYTE         <= 1'b0;
      BYTE_TO_SEND      <= 8'h00;
      READ_ENABLE       <= 1'b0;
      MOUSE_STATUS      <= '0;
      MOUSE_DX          <= '0;
      MOUSE_DY          <= '0;
      SEND_INTERRUPT    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      READ_ENABLE <= is_read_state(state_next);
      SEND_BYTE   <= (state_next == SEND_FF) || (state_next == SEND_F4);
      if (state_next == SEND_FF) BYTE_TO_SEND <= 8'hFF;
      else if (state_next == SEND_F4) BYTE_TO_SEND <= 8'hF4;

      if (state_next != state_reg) cnt_reg <= '0;
      else if (state_reg == INIT || is_wait) cnt_reg <= cnt_reg + 32'd1;
      else if (WATCHDOG && in_mid_packet && !BYTE_READY) cnt_reg <= cnt_reg + 32'd1;
      else cnt_reg <= '0;

      if (rx_good) begin
        case (state_reg)
          STREAM_B1, PUBLISH: if (BYTE_READ[3]) shadow_status_reg <= BYTE_READ;
          STREAM_B2:          shadow_dx_reg <= BYTE_READ;
          STREAM_B3:          shadow_dy_reg <= BYTE_READ;
          default:            ;
        endcase
      end

      SEND_INTERRUPT <= (state_reg == PUBLISH);
      if (state_reg == PUBLISH) begin
        MOUSE_STATUS <= shadow_status_reg;
        MOUSE_DX     <= shadow_dx_reg;
        MOUSE_DY     <= shadow_dy_reg;
      end
    end
  end

endmodule

// File: tb/tb_mouse_master_sm.sv
// Directed testbench for mouse_master_sm with shortened INIT_WAIT / RESP_TIMEOUT.
module tb_mouse_master_sm;
  localparam int INIT_WAIT    = 20;
  localparam int RESP_TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send_byte;
  logic [7:0] byte_to_send;
  logic       byte_sent;
  logic       read_enable;
  logic [7:0] byte_read;
  logic [1:0] byte_error_code;
  logic       byte_ready;
  logic [7:0] mouse_status, mouse_dx, mouse_dy;
  logic       send_interrupt;
  logic [3:0] master_state;

  int tests_run = 0;
  int tests_failed = 0;
  int irq_count = 0;

  mouse_master_sm #(.INIT_WAIT(INIT_WAIT), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .CLK(clk), .RESET(rst_n), .SEND_BYTE(send_byte), .BYTE_TO_SEND(byte_to_send),
    .BYTE_SENT(byte_sent), .READ_ENABLE(read_enable), .BYTE_READ(byte_read),
    .BYTE_ERROR_CODE(byte_error_code), .BYTE_READY(byte_ready),
    .MOUSE_STATUS(mouse_status), .MOUSE_DX(mouse_dx), .MOUSE_DY(mouse_dy),
    .SEND_INTERRUPT(send_interrupt), .MASTER_STATE(master_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (send_interrupt) irq_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else
      $display("[TB] ok %s = %0h", name, got);
  endtask

  task automatic rx(input logic [7:0] b, input logic [1:0] err);
    byte_read = b; byte_error_code = err; byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0; byte_error_code = 2'b00;
  endtask

  task automatic sent();
    byte_sent = 1'b1;
    tick();
    byte_sent = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Cycles from now until SEND_BYTE is seen high; -1 if it never comes
  task automatic wait_send(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (send_byte === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic handshake_quiet();
    int n;
    do_reset();
    wait_send(n);
    tick(); sent();
    rx(8'hFA, 2'b00); rx(8'hAA, 2'b00); rx(8'h00, 2'b00);
    tick(); sent();
    rx(8'hFA, 2'b00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_state", master_state, 0);
    chk("reset_send_byte", send_byte, 0);
    chk("reset_byte_to_send", byte_to_send, 0);
    chk("reset_read_enable", read_enable, 0);
    chk("reset_irq", send_interrupt, 0);
    chk("reset_status", mouse_status, 0);
  endtask

  task automatic test_handshake();
    int n;
    rst_n = 1'b1;
    wait_send(n);
    chk("init_wait_cycles", n, INIT_WAIT);
    chk("send_ff_byte", byte_to_send, 8'hFF);
    chk("send_ff_state", master_state, 1);
    tick();
    chk("send_ff_pulse_width", send_byte, 0);
    chk("wait_sent_ff_state", master_state, 2);
    chk("wait_sent_ff_hold", byte_to_send, 8'hFF);
    sent();
    chk("wait_fa1_state", master_state, 3);
    chk("wait_fa1_read_en", read_enable, 1);
    sent();
    chk("stray_byte_sent_ignored", master_state, 3);
    rx(8'hFA, 2'b00);
    chk("wait_aa_state", master_state, 4);
    rx(8'hAA, 2'b00);
    chk("wait_id_state", master_state, 5);
    rx(8'h00, 2'b00);
    chk("send_f4_state", master_state, 6);
    chk("send_f4_pulse", send_byte, 1);
    chk("send_f4_byte", byte_to_send, 8'hF4);
    chk("send_f4_read_en", read_enable, 0);
    tick();
    chk("send_f4_pulse_width", send_byte, 0);
    chk("wait_sent_f4_state", master_state, 7);
    sent();
    chk("wait_fa2_state", master_state, 8);
    rx(8'hFA, 2'b00);
    chk("stream_b1_state", master_state, 9);
    chk("stream_read_en", read_enable, 1);
  endtask

  task automatic test_packet();
    int irq0;
    irq0 = irq_count;
    rx(8'h09, 2'b00);
    chk("pkt_b2_state", master_state, 10);
    rx(8'h05, 2'b00);
    chk("pkt_b3_state", master_state, 11);
    rx(8'hFB, 2'b00);
    chk("pkt_publish_state", master_state, 12);
    chk("pkt_irq_not_yet", send_interrupt, 0);
    chk("pkt_status_held", mouse_status, 0);
    tick();
    chk("pkt_irq_latency2", send_interrupt, 1);
    chk("pkt_status", mouse_status, 8'h09);
    chk("pkt_dx", mouse_dx, 8'h05);
    chk("pkt_dy", mouse_dy, 8'hFB);
    tick();
    chk("pkt_irq_width", send_interrupt, 0);
    chk("pkt_dy_hold", mouse_dy, 8'hFB);
    chk("pkt_irq_count", irq_count - irq0, 1);
  endtask

  task automatic test_sync_error();
    int irq0;
    irq0 = irq_count;
    rx(8'h01, 2'b00);
    chk("sync_drop_state", master_state, 9);
    rx(8'h28, 2'b00); rx(8'h10, 2'b00); rx(8'h20, 2'b00);
    tick();
    chk("sync_status", mouse_status, 8'h28);
    chk("sync_dx", mouse_dx, 8'h10);
    chk("sync_dy", mouse_dy, 8'h20);
    tick();
    chk("sync_irq_count", irq_count - irq0, 1);
  endtask

  task automatic test_stream_error();
    rx(8'h08, 2'b00);
    rx(8'h11, 2'b01);
    chk("stream_err_to_b1", master_state, 9);
    rx(8'h3C, 2'b10);
    chk("stream_err_b1_stay", master_state, 9);
    chk("stream_err_no_publish", mouse_status, 8'h28);
  endtask

  task automatic test_back_to_back();
    rx(8'h0A, 2'b00); rx(8'h7F, 2'b00); rx(8'h80, 2'b00);
    chk("b2b_publish_state", master_state, 12);
    rx(8'h18, 2'b00);
    chk("b2b_irq", send_interrupt, 1);
    chk("b2b_status_first", mouse_status, 8'h0A);
    chk("b2b_dx_first", mouse_dx, 8'h7F);
    chk("b2b_byte_kept_state", master_state, 10);
    rx(8'h02, 2'b00); rx(8'h03, 2'b00);
    tick();
    chk("b2b_status_second", mouse_status, 8'h18);
    chk("b2b_dy_second", mouse_dy, 8'h03);
    tick();
  endtask

  task automatic test_async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", master_state, 0);
    chk("async_rst_status", mouse_status, 0);
    chk("async_rst_read_en", read_enable, 0);
    tick();
  endtask

  task automatic test_bad_aa();
    int n;
    do_reset();
    wait_send(n);
    tick(); sent();
    rx(8'hFA, 2'b00);
    rx(8'hAB, 2'b00);
    chk("bad_aa_to_init", master_state, 0);
    chk("bad_aa_read_en", read_enable, 0);
    wait_send(n);
    chk("bad_aa_resend_cycles", n, INIT_WAIT);
    chk("bad_aa_resend_byte", byte_to_send, 8'hFF);
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    wait_send(n);
    tick(); sent();
    repeat (RESP_TIMEOUT - 1) tick();
    chk("timeout_not_yet", master_state, 3);
    tick();
    chk("timeout_to_init", master_state, 0);
    wait_send(n);
    chk("timeout_resend_cycles", n, INIT_WAIT);
    chk("timeout_resend_byte", byte_to_send, 8'hFF);
  endtask

  task automatic test_reset_mid_send();
    int n;
    do_reset();
    wait_send(n);
    tick(); sent();
    rx(8'hFA, 2'b00); rx(8'hAA, 2'b00); rx(8'h00, 2'b00);
    chk("mid_send_setup", send_byte, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_send_byte_cleared", send_byte, 0);
    chk("mid_send_data_cleared", byte_to_send, 0);
    chk("mid_send_state", master_state, 0);
    tick();
  endtask

  task automatic test_watchdog();
    int irq0;
    handshake_quiet();
    irq0 = irq_count;
    rx(8'h08, 2'b00);
    chk("wd_in_b2", master_state, 10);
    repeat (RESP_TIMEOUT - 1) tick();
    chk("wd_not_yet", master_state, 10);
    tick();
`ifdef MOUSE_STREAM_WATCHDOG_EN
    chk("wd_expired_b1", master_state, 9);
`else
    chk("wd_absent_b2", master_state, 10);
`endif
    tick();
    chk("wd_no_irq", irq_count - irq0, 0);
  endtask

  initial begin
    rst_n = 1'b0; byte_sent = 1'b0; byte_read = 8'h00;
    byte_error_code = 2'b00; byte_ready = 1'b0;
    #2;
    test_reset();
    test_handshake();
    test_packet();
    test_sync_error();
    test_stream_error();
    test_back_to_back();
    test_async_reset();
    test_bad_aa();
    test_timeout();
    test_reset_mid_send();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
